// File: rtl/gamepad_scan_ctrl.sv
// Multi-pad serial gamepad scanner: drives a shared latch/pulse pair, shifts in every pad
// in parallel and publishes per-frame button words, press edges and sticky press flags.
module gamepad_scan_ctrl #(
  parameter int NUM_PADS     = 2,
  parameter int BITS_PER_PAD = 8,
  parameter int CLK_DIV      = 300,
  parameter int POLL_CYCLES  = 833333,
  parameter bit AUTO_POLL    = 1'b1,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_PADS-1:0]              PadData,
  input  logic                             Poll,
  input  logic                             ClearPressed,
  output logic                             PadLatch,
  output logic                             PadPulse,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] Buttons,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] PressedEdge,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] PressedSticky,
  output logic                             SampleValid,
  output logic                             Busy
);

  localparam int unsigned NP = NUM_PADS;
  localparam int unsigned B  = BITS_PER_PAD;
  localparam int unsigned W  = NUM_PADS * BITS_PER_PAD;
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int BW = (BITS_PER_PAD > 2) ? $clog2(BITS_PER_PAD - 1) : 1;

  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'((BITS_PER_PAD > 1) ? BITS_PER_PAD - 2 : 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [BW-1:0]              bit_q, bit_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic                       pend_q, pend_d;
  logic [NP-1:0][B-1:0]       sr_q, sr_d;
  logic                       shift_en;
  logic                       start_req;
  logic [W-1:0]               new_word;

  logic                       latch_q, pulse_q, valid_q;
  logic [W-1:0]               buttons_q, edge_q, sticky_q;

  assign timer_d   = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
  assign start_req = Poll | (AUTO_POLL && (timer_q == TIMER_LAST));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    pend_d   = pend_q | start_req;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (start_req || pend_q) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          bit_d    = '0;
          state_d  = (B == 1) ? DONE : PULSE_HI;
        end
      end
      PULSE_HI: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (cnt_q == HALF_LAST) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = PULSE_HI;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each pad shifts toward bit 0, so after B shifts the first bit received sits at bit 0.
  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      for (int unsigned k = 0; k < NP; k++) begin
        for (int unsigned i = 0; i + 1 < B; i++) begin
          sr_d[k][i] = sr_q[k][i+1];
        end
        sr_d[k][B-1] = PadData[k];
      end
    end
  end

  assign new_word = ACTIVE_LOW ? ~sr_d : sr_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      sr_q    <= sr_d;
    end
  end

  // Outputs register off the next state so they line up with the state they belong to;
  // sticky folds in the edge word during DONE so a coincident clear keeps the new edges.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      buttons_q <= '0;
      edge_q    <= '0;
      sticky_q  <= '0;
    end else begin
      latch_q <= (state_d == LATCH);
      pulse_q <= (state_d == PULSE_HI);
      valid_q <= (state_d == DONE);
      if (state_d == DONE) begin
        buttons_q <= new_word;
        edge_q    <= new_word & ~buttons_q;
      end else begin
        edge_q <= '0;
      end
      if (state_q == DONE) begin
        sticky_q <= (ClearPressed ? '0 : sticky_q) | edge_q;
      end else if (ClearPressed) begin
        sticky_q <= '0;
      end
    end
  end

  assign PadLatch      = latch_q;
  assign PadPulse      = pulse_q;
  assign SampleValid   = valid_q;
  assign Buttons       = buttons_q;
  assign PressedEdge   = edge_q;
  assign PressedSticky = sticky_q;
  assign Busy          = (state_q != IDLE);

endmodule

// File: tb/tb_gamepad_scan_ctrl.sv
// Bench for gamepad_scan_ctrl: behavioural pad shift registers plus a frame-level model of
// button words, press edges and sticky flags; a second instance exercises Poll-only mode.
module tb_gamepad_scan_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic [1:0]  PadData;
  logic        Poll, Poll_m, ClearPressed, Clear_m;
  logic        PadLatch, PadPulse, SampleValid, Busy;
  logic [15:0] Buttons, PressedEdge, PressedSticky;
  logic        PadLatch_m, PadPulse_m, SampleValid_m, Busy_m;
  logic [15:0] Buttons_m, PressedEdge_m, PressedSticky_m;
  logic [1:0]  pd_m = 2'b11;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  pat0, pat1, sr0, sr1;
  logic        pulse_prev = 1'b0;
  logic [15:0] m_btn, m_sticky;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gamepad_scan_ctrl #(
    .NUM_PADS(2), .BITS_PER_PAD(8), .CLK_DIV(4), .POLL_CYCLES(200),
    .AUTO_POLL(1'b1), .ACTIVE_LOW(1'b1)
  ) dut (
    .Clock(clk), .Reset(Reset), .PadData(PadData), .Poll(Poll),
    .ClearPressed(ClearPressed), .PadLatch(PadLatch), .PadPulse(PadPulse),
    .Buttons(Buttons), .PressedEdge(PressedEdge), .PressedSticky(PressedSticky),
    .SampleValid(SampleValid), .Busy(Busy)
  );

  gamepad_scan_ctrl #(
    .NUM_PADS(2), .BITS_PER_PAD(8), .CLK_DIV(4), .POLL_CYCLES(200),
    .AUTO_POLL(1'b0), .ACTIVE_LOW(1'b1)
  ) dut_m (
    .Clock(clk), .Reset(Reset), .PadData(pd_m), .Poll(Poll_m),
    .ClearPressed(Clear_m), .PadLatch(PadLatch_m), .PadPulse(PadPulse_m),
    .Buttons(Buttons_m), .PressedEdge(PressedEdge_m), .PressedSticky(PressedSticky_m),
    .SampleValid(SampleValid_m), .Busy(Busy_m)
  );

  // 4021-style pad: parallel load while latch is high, shift on each rising pulse.
  always @(negedge clk) begin
    if (PadLatch) begin
      sr0 <= pat0;
      sr1 <= pat1;
    end else if (PadPulse && !pulse_prev) begin
      sr0 <= {1'b1, sr0[7:1]};
      sr1 <= {1'b1, sr1[7:1]};
    end
    pulse_prev <= PadPulse;
  end
  assign PadData = {sr1[0], sr0[0]};

  always @(negedge clk) begin
    checks++;
    assert (!(PadLatch && PadPulse)) else begin
      errors++;
      $error("FAIL latch_pulse_overlap: observed %b%b expected not both high", PadLatch, PadPulse);
    end
    if (!SampleValid) begin
      checks++;
      assert (PressedEdge === 16'h0) else begin
        errors++;
        $error("FAIL edge_outside_valid: observed %h expected 0000", PressedEdge);
      end
    end
  end

  initial begin
    #2_000_000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return PadLatch;
      1: return SampleValid;
      2: return PadPulse;
      3: return PadLatch_m;
      default: return SampleValid_m;
    endcase
  endfunction

  task automatic wait_hi(input int which, input int budget, input string tag, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(which) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
  endtask

  // One full frame against the model; returns the cycle of the LATCH rise.
  task automatic do_scan(input logic [7:0] p0, input logic [7:0] p1, input bit clear,
                         input string tag, output int c0);
    int cv;
    logic [15:0] nb, ne;
    pat0 = p0;
    pat1 = p1;
    wait_hi(0, 260, {tag, "_latch"}, c0);
    wait_hi(1, 100, {tag, "_valid"}, cv);
    chk({tag, "_latency"}, 32'(cv - c0), 32'd64);
    nb = ~{p1, p0};
    ne = nb & ~m_btn;
    chk({tag, "_buttons"}, 32'(Buttons), 32'(nb));
    chk({tag, "_edge"}, 32'(PressedEdge), 32'(ne));
    m_sticky = clear ? ne : (m_sticky | ne);
    m_btn = nb;
    ClearPressed = clear;
    @(negedge clk);
    ClearPressed = 1'b0;
    chk({tag, "_sticky"}, 32'(PressedSticky), 32'(m_sticky));
    chk({tag, "_valid_drop"}, 32'(SampleValid), 32'd0);
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
    chk({tag, "_hold"}, 32'(Buttons), 32'(nb));
  endtask

  initial begin
    int r0, c0, cv, n;
    logic [7:0] rp0, rp1;
    Reset = 1'b1;
    Poll = 1'b0;
    Poll_m = 1'b0;
    ClearPressed = 1'b0;
    Clear_m = 1'b0;
    pat0 = 8'hFF;
    pat1 = 8'hFF;
    m_btn = '0;
    m_sticky = '0;

    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(PadLatch), 32'd0);
    chk("rst_pulse", 32'(PadPulse), 32'd0);
    chk("rst_buttons", 32'(Buttons), 32'd0);
    chk("rst_edge", 32'(PressedEdge), 32'd0);
    chk("rst_sticky", 32'(PressedSticky), 32'd0);
    chk("rst_valid", 32'(SampleValid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    r0 = cyc;

    do_scan(8'hFE, 8'hFF, 1'b0, "scan1", c0);
    chk("first_latch_delay", 32'(c0 - r0), 32'd200);
    chk("manual_no_autopoll", 32'(Busy_m), 32'd0);
    do_scan(8'hFE, 8'hFF, 1'b0, "scan2", c0);
    do_scan(8'hFE, 8'hF7, 1'b1, "clear_coincident", c0);
    chk("clear_sticky_word", 32'(PressedSticky), 32'h0800);

    for (int i = 0; i < 5; i++) begin
      rp0 = 8'($urandom);
      rp1 = 8'($urandom);
      do_scan(rp0, rp1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i), c0);
    end

    // Poll-only instance: one start, two requests while busy collapse into one rescan.
    @(negedge clk);
    Poll_m = 1'b1;
    @(negedge clk);
    Poll_m = 1'b0;
    chk("poll_start", 32'(PadLatch_m), 32'd1);
    repeat (10) @(negedge clk);
    Poll_m = 1'b1;
    @(negedge clk);
    Poll_m = 1'b0;
    repeat (5) @(negedge clk);
    Poll_m = 1'b1;
    @(negedge clk);
    Poll_m = 1'b0;
    wait_hi(4, 100, "poll_valid1", cv);
    @(negedge clk);
    chk("poll_idle_return", 32'(Busy_m), 32'd0);
    @(negedge clk);
    chk("poll_pending_start", 32'(PadLatch_m), 32'd1);
    wait_hi(4, 100, "poll_valid2", cv);
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (Busy_m) n++;
    end
    chk("poll_no_extra_scan", 32'(n), 32'd0);

    // Reset in the middle of a pulse-high phase.
    wait_hi(0, 260, "mid_latch", c0);
    wait_hi(2, 40, "mid_pulse", cv);
    Reset = 1'b1;
    @(negedge clk);
    chk("midrst_pulse", 32'(PadPulse), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_buttons", 32'(Buttons), 32'd0);
    chk("midrst_sticky", 32'(PressedSticky), 32'd0);
    Reset = 1'b0;
    r0 = cyc;
    m_btn = '0;
    m_sticky = '0;
    rp0 = 8'($urandom);
    rp1 = 8'($urandom);
    do_scan(rp0, rp1, 1'b0, "after_rst", c0);
    chk("after_rst_delay", 32'(c0 - r0), 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
